// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register map, STATUS bit positions and TX FSM encoding for uart_ctrl
package uart_ctrl_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUDLO = 2'd2;
  localparam logic [1:0] ADDR_BAUDHI = 2'd3;
  localparam int ST_RXAVAIL = 0;
  localparam int ST_TXNOTFULL = 1;
  localparam int ST_TXIDLE = 2;
  localparam int ST_RXOVR = 3;
  localparam int ST_TXOVF = 4;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} txState_t;
endpackage

// File: rtl/uart_ctrl_fifo.sv
// sync_fifo: 8-bit synchronous FIFO, 2^DEPTH_LOG2 entries, extra pointer bit distinguishes full from empty
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] pushData,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  logic [DEPTH_LOG2:0] wrPtr, rdPtr;
  logic [7:0] mem [2**DEPTH_LOG2];
  logic doPop, doPush;
  assign empty = wrPtr == rdPtr;
  assign full = (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]) && (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]);
  assign doPop = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head = mem[rdPtr[DEPTH_LOG2-1:0]];
  // pointer advance; a pop frees the slot so a push on a full FIFO still lands
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  // storage, no reset needed since empty gates every read
  always_ff @(posedge clock)
    if (doPush) mem[wrPtr[DEPTH_LOG2-1:0]] <= pushData;
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU register front-end for the uart (TX/RX FIFOs, baudDiv); optional irq with UART_CTRL_IRQ_EN
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter logic [15:0] BAUD_DEFAULT = 16'd26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  wrData,
  output logic [7:0]  rdData,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txBusy,
  input  logic        txDone,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [15:0] baudDiv
`ifdef UART_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);
  txState_t state, nextState;
  logic txPush, txPop, txFull, txEmpty, txIdle, txDrop;
  logic rxPop, rxFull, rxEmpty, rxDrop, rxOvr, txOvf, statusRead;
  logic [7:0] txHead, rxHead, status, rdNext;
  assign txPush = wr && addr == ADDR_DATA;
  assign txDrop = txPush && txFull && !txPop;
  assign rxPop = rd && addr == ADDR_DATA && !rxEmpty;
  assign rxDrop = rxValid && rxFull && !rxPop;
  assign statusRead = rd && addr == ADDR_STATUS;
  assign txIdle = txEmpty && state == IDLE;
  assign txValid = state == LAUNCH;
  sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) txFifo (
    .clock(clock), .reset(reset), .push(txPush), .pop(txPop), .pushData(wrData),
    .head(txHead), .full(txFull), .empty(txEmpty)
  );
  sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) rxFifo (
    .clock(clock), .reset(reset), .push(rxValid), .pop(rxPop), .pushData(rxData),
    .head(rxHead), .full(rxFull), .empty(rxEmpty)
  );
  // TX sequencing: pop on leaving IDLE, pulse in LAUNCH, then track the uart busy/done handshake
  always_comb begin
    nextState = state;
    txPop = 1'b0;
    case (state)
      IDLE: if (!txEmpty && !txBusy) begin
        nextState = LAUNCH;
        txPop = 1'b1;
      end
      LAUNCH: nextState = WAIT_BUSY;
      WAIT_BUSY: if (txBusy) nextState = WAIT_DONE;
      WAIT_DONE: if (txDone || !txBusy) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  // STATUS image and read-data mux
  always_comb begin
    status = '0;
    status[ST_RXAVAIL] = !rxEmpty;
    status[ST_TXNOTFULL] = !txFull;
    status[ST_TXIDLE] = txIdle;
    status[ST_RXOVR] = rxOvr;
    status[ST_TXOVF] = txOvf;
    rdNext = addr == ADDR_DATA ? (rxEmpty ? 8'h00 : rxHead) :
             addr == ADDR_STATUS ? status :
             addr == ADDR_BAUDLO ? baudDiv[7:0] : baudDiv[15:8];
  end
  // state, launch byte, read data, baud register and sticky flags (a STATUS read clears what it captured)
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      txData <= 8'h00;
      rdData <= 8'h00;
      baudDiv <= BAUD_DEFAULT;
      rxOvr <= 1'b0;
      txOvf <= 1'b0;
    end else begin
      state <= nextState;
      if (txPop) txData <= txHead;
      if (rd) rdData <= rdNext;
      if (wr && addr == ADDR_BAUDLO) baudDiv[7:0] <= wrData;
      if (wr && addr == ADDR_BAUDHI) baudDiv[15:8] <= wrData;
      rxOvr <= (statusRead ? 1'b0 : rxOvr) | rxDrop;
      txOvf <= (statusRead ? 1'b0 : txOvf) | txDrop;
    end
`ifdef UART_CTRL_IRQ_EN
  logic [1:0] irqEn;
  // interrupt enables written at the STATUS address, irq registered from the enabled sources
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      irqEn <= 2'b00;
      irq <= 1'b0;
    end else begin
      if (wr && addr == ADDR_STATUS) irqEn <= wrData[1:0];
      irq <= (irqEn[0] && !rxEmpty) || (irqEn[1] && txIdle);
    end
`endif
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl with a simple uart transmitter model
module tb_uart_ctrl;
  logic clock = 0, reset = 1;
  logic [1:0] addr = 0;
  logic wr = 0, rd = 0;
  logic [7:0] wrData = 0, rdData, txData, rxData = 0;
  logic txValid, txBusy, txDone, rxValid = 0;
  logic [15:0] baudDiv;
  logic holdBusy = 0, modelBusy = 0, modelDone = 0;
  int modelCnt = 0, busyPulses = 0, checks = 0, failures = 0, n;
  logic [7:0] sent [$];
  logic [7:0] d;

  assign txBusy = holdBusy | modelBusy;
  assign txDone = modelDone;

  uart_ctrl dut (
    .clock(clock), .reset(reset), .addr(addr), .wr(wr), .rd(rd), .wrData(wrData),
    .rdData(rdData), .txData(txData), .txValid(txValid), .txBusy(txBusy), .txDone(txDone),
    .rxData(rxData), .rxValid(rxValid), .baudDiv(baudDiv)
  );

  always #5 clock = ~clock;

  // uart model: busy for 10 cycles after each launch, then a one-cycle done pulse
  always @(posedge clock) begin
    modelDone <= 1'b0;
    if (txValid) begin
      if (txBusy) busyPulses++;
      sent.push_back(txData);
      modelBusy <= 1'b1;
      modelCnt <= 10;
    end else if (modelBusy) begin
      if (modelCnt == 1) begin
        modelBusy <= 1'b0;
        modelDone <= 1'b1;
      end
      modelCnt <= modelCnt - 1;
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wrReg(input logic [1:0] a, input logic [7:0] v);
    addr = a; wrData = v; wr = 1;
    tick();
    wr = 0;
  endtask

  task automatic rdReg(input logic [1:0] a, output logic [7:0] v);
    addr = a; rd = 1;
    tick();
    rd = 0;
    v = rdData;
  endtask

  initial begin
    tick(3);
    check("reset_rdData", {8'h0, rdData}, 16'h0000);
    check("reset_txValid", {15'h0, txValid}, 16'h0000);
    check("reset_baudDiv", baudDiv, 16'h001A);
    reset = 0;
    tick();
    rdReg(2'd1, d); check("reset_status", {8'h0, d}, 16'h0006);
    rdReg(2'd2, d); check("reset_baudlo", {8'h0, d}, 16'h001A);
    rdReg(2'd3, d); check("reset_baudhi", {8'h0, d}, 16'h0000);
    rdReg(2'd0, d); check("reset_data", {8'h0, d}, 16'h0000);

    sent.delete();
    wrReg(2'd0, 8'h41); wrReg(2'd0, 8'h42); wrReg(2'd0, 8'h43);
    tick(100);
    check("tx3_count", sent.size(), 16'd3);
    if (sent.size() == 3) begin
      check("tx3_byte0", {8'h0, sent[0]}, 16'h0041);
      check("tx3_byte1", {8'h0, sent[1]}, 16'h0042);
      check("tx3_byte2", {8'h0, sent[2]}, 16'h0043);
    end
    check("tx3_nobusypulse", busyPulses, 16'd0);
    rdReg(2'd1, d); check("tx3_status_idle", {8'h0, d}, 16'h0006);

    holdBusy = 1;
    tick();
    sent.delete();
    for (int i = 0; i < 17; i++) wrReg(2'd0, 8'h60 + 8'(i));
    rdReg(2'd1, d); check("txovf_status", {8'h0, d}, 16'h0010);
    rdReg(2'd1, d); check("txovf_status_cleared", {8'h0, d}, 16'h0000);
    holdBusy = 0;
    tick(400);
    check("txovf_count16", sent.size(), 16'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      check($sformatf("txovf_byte%0d", i), {8'h0, sent[i]}, 16'h0060 + 16'(i));
    check("txovf_nobusypulse", busyPulses, 16'd0);
    rdReg(2'd1, d); check("txovf_status_idle", {8'h0, d}, 16'h0006);

    for (int i = 0; i < 17; i++) begin
      rxData = 8'(i); rxValid = 1;
      tick();
    end
    rxValid = 0;
    rdReg(2'd1, d); check("rxovr_status", {8'h0, d}, 16'h000F);
    for (int i = 0; i < 16; i++) begin
      rdReg(2'd0, d);
      check($sformatf("rxovr_data%0d", i), {8'h0, d}, 16'(i));
    end
    rdReg(2'd1, d); check("rxovr_status_empty", {8'h0, d}, 16'h0006);

    for (int i = 0; i < 16; i++) begin
      rxData = 8'h80 + 8'(i); rxValid = 1;
      tick();
    end
    rxData = 8'h90; rxValid = 1; addr = 2'd0; rd = 1;
    tick();
    rxValid = 0; rd = 0;
    check("rxfull_pushpop_head", {8'h0, rdData}, 16'h0080);
    rdReg(2'd1, d); check("rxfull_pushpop_status", {8'h0, d}, 16'h0007);
    for (int i = 0; i < 16; i++) begin
      rdReg(2'd0, d);
      check($sformatf("rxfull_data%0d", i), {8'h0, d}, 16'h0081 + 16'(i));
    end

    wrReg(2'd2, 8'h34); check("baudlo_write", baudDiv, 16'h0034);
    wrReg(2'd3, 8'h12); check("baudhi_write", baudDiv, 16'h1234);
    wrReg(2'd1, 8'hFF); check("status_write_ignored", baudDiv, 16'h1234);
    rdReg(2'd2, d); check("baudlo_read", {8'h0, d}, 16'h0034);
    rdReg(2'd3, d); check("baudhi_read", {8'h0, d}, 16'h0012);

    wrReg(2'd0, 8'h55); wrReg(2'd0, 8'h56);
    check("midtx_launch", {15'h0, txValid}, 16'h0001);
    tick();
    reset = 1;
    #1;
    check("midtx_reset_txValid", {15'h0, txValid}, 16'h0000);
    check("midtx_reset_baudDiv", baudDiv, 16'h001A);
    check("midtx_reset_rdData", {8'h0, rdData}, 16'h0000);
    tick(2);
    reset = 0;
    n = sent.size();
    tick();
    rdReg(2'd1, d); check("midtx_status_empty", {8'h0, d}, 16'h0006);
    rdReg(2'd0, d); check("midtx_rx_empty", {8'h0, d}, 16'h0000);
    tick(40);
    check("midtx_no_more_pulses", sent.size(), 16'(n));
    check("midtx_nobusypulse", busyPulses, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
